// File: rtl/nonce_tx_queue.sv
// -----------------------------------------------------------------------------
// nonce_tx_queue
//
// Buffers 32-bit golden nonces from the hashing cores in a small FIFO and
// hands them one at a time to the serial core over its tx_ready / word /
// tx_busy handshake. A nonce found while an earlier one is still shifting out
// waits in the queue instead of being lost. new_work discards every queued
// nonce, because results for the old work are worthless.
//
// Parameters
//   DEPTH_LOG2    log2 of FIFO depth (1..6, default 3 -> 8 entries)
//   BUSY_TIMEOUT  cycles to wait for tx_busy after a request before the same
//                 nonce is requested again (2..15)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   nonce_in     golden nonce from the hashing cores
//   nonce_valid  single-cycle strobe qualifying nonce_in
//   new_work     single-cycle strobe: new work latched, discard queued nonces
//   tx_busy      serial core is transmitting
//   tx_ready     single-cycle send request to the serial core
//   word         nonce presented to the serial core
//   fifo_count   current FIFO occupancy (0 .. 2**DEPTH_LOG2)
//   overflow     sticky; a nonce was dropped because the FIFO was full
//
// Optional feature (compile-time macro NONCE_DEDUP_EN)
//   When defined, a nonce equal to the most recently pushed nonce is dropped
//   silently, which suppresses duplicates reported by redundant cores.
// -----------------------------------------------------------------------------
module nonce_tx_queue #(
    parameter int DEPTH_LOG2   = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           nonce_in,
    input  logic                  nonce_valid,
    input  logic                  new_work,
    input  logic                  tx_busy,
    output logic                  tx_ready,
    output logic [31:0]           word,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [3:0]          TIMEOUT  = 4'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   tx_ready_q, tx_ready_d;
    logic [31:0]            word_q, word_d;
    logic [3:0]             timer_q, timer_d;
    // Set when the FIFO is flushed while a request is in flight: the word being
    // sent no longer has a FIFO entry behind it, so it must not be popped.
    logic                   flushed_q, flushed_d;

    logic full;
    logic pop;
    logic push;
    logic is_dup;

`ifdef NONCE_DEDUP_EN
    logic [31:0] last_q, last_d;
    logic        last_vld_q, last_vld_d;

    assign is_dup = last_vld_q && (nonce_in == last_q);

    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (new_work) begin
            last_d     = '0;
            last_vld_d = 1'b0;
        end else if (push) begin
            last_d     = nonce_in;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    assign full = (count_q == FULL_CNT);
    // A flush in the same cycle wins over the pop.
    assign pop  = (state_q == WAIT_BUSY) && tx_busy && !new_work && !flushed_q
                  && (count_q != '0);
    // When full, a same-cycle pop frees the slot the push needs.
    assign push = nonce_valid && !new_work && !is_dup && (!full || pop);

    // FIFO pointers, occupancy and overflow flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (new_work) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
                default: count_d = count_q;
            endcase
            if (nonce_valid && !is_dup && full && !pop) overflow_d = 1'b1;
        end
    end

    // Read FSM
    always_comb begin
        state_d    = state_q;
        tx_ready_d = 1'b0;
        word_d     = word_q;
        timer_d    = timer_q;
        flushed_d  = flushed_q;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !tx_busy) begin
                    word_d     = mem_q[rd_ptr_q];
                    tx_ready_d = 1'b1;
                    timer_d    = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    timer_d = timer_q + 4'd1;
                    // Serial core never picked it up: re-request the same head.
                    if (timer_d == TIMEOUT) state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            flushed_d = 1'b0;
        end else if (new_work) begin
            flushed_d = 1'b1;
        end
    end

    // Storage carries no reset; fifo_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= nonce_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_ready_q <= 1'b0;
            word_q     <= '0;
            timer_q    <= '0;
            flushed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_ready_q <= tx_ready_d;
            word_q     <= word_d;
            timer_q    <= timer_d;
            flushed_q  <= flushed_d;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign word       = word_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
